// File: rtl/buffer_drain_accumulator.sv
// Drains COUNT words from an upstream circular buffer, sums them and holds the result for a ready/valid consumer.
// Optional macro ACC_SATURATE_EN: clamp the sum at 2^SUM_W-1 and flag sat; otherwise the sum wraps and sat is 0.
module buffer_drain_accumulator #(
    parameter int DATA_W = 3,
    parameter int COUNT  = 8,
    parameter int SUM_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              empty,
    input  logic [DATA_W-1:0] din,
    output logic              rd,
    output logic [SUM_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              sat
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam int EXT_W = SUM_W + 1;
    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  issued_r;
    logic [CNT_W-1:0]  accepted_r;
    logic              rd_q_r;
    logic [SUM_W-1:0]  acc_r;
    logic [SUM_W-1:0]  acc_next_s;
    logic              sat_r;
    logic              sat_next_s;
    logic [SUM_W-1:0]  sum_r;
    logic              sum_valid_r;
    logic [EXT_W-1:0]  add_s;
    logic              rd_s;
    logic              last_s;
    logic              consume_s;

    // Read request, word-capture bookkeeping and the next accumulator value.
    always_comb begin
        rd_s       = 1'b0;
        add_s      = {1'b0, acc_r} + EXT_W'(din);
        acc_next_s = add_s[SUM_W-1:0];
        sat_next_s = 1'b0;
        if ((state_r == COLLECT) && !empty && (issued_r < COUNT_C) && !reset) begin
            rd_s = 1'b1;
        end else begin
            rd_s = 1'b0;
        end
`ifdef ACC_SATURATE_EN
        // The carry out of the widened add means the true sum no longer fits.
        if (add_s[SUM_W]) begin
            acc_next_s = {SUM_W{1'b1}};
            sat_next_s = 1'b1;
        end else begin
            acc_next_s = add_s[SUM_W-1:0];
            sat_next_s = sat_r;
        end
`else
        acc_next_s = add_s[SUM_W-1:0];
        sat_next_s = 1'b0;
`endif
        last_s    = rd_q_r && (accepted_r == (COUNT_C - ONE_C));
        consume_s = sum_valid_r && sum_ready;
    end

    // Next-state logic for the COLLECT/HOLD controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: begin
                if (last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: state_next_s = COLLECT;
        endcase
    end

    // State, counters, accumulator and the held result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= COLLECT;
            issued_r    <= '0;
            accepted_r  <= '0;
            rd_q_r      <= 1'b0;
            acc_r       <= '0;
            sat_r       <= 1'b0;
            sum_r       <= '0;
            sum_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rd_q_r  <= rd_s;
            if (consume_s) begin
                issued_r    <= '0;
                accepted_r  <= '0;
                acc_r       <= '0;
                sat_r       <= 1'b0;
                sum_valid_r <= 1'b0;
            end else begin
                if (rd_s) begin
                    issued_r <= issued_r + ONE_C;
                end
                // din is the buffer's dout for the read issued last cycle.
                if (rd_q_r) begin
                    acc_r      <= acc_next_s;
                    sat_r      <= sat_next_s;
                    accepted_r <= accepted_r + ONE_C;
                end
                if (last_s) begin
                    sum_r       <= acc_next_s;
                    sum_valid_r <= 1'b1;
                end
            end
        end
    end

    assign rd        = rd_s;
    assign sum       = sum_r;
    assign sum_valid = sum_valid_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_buffer_drain_accumulator.sv
// Directed self-checking bench for buffer_drain_accumulator (default build and COUNT=32 instance).
module tb_buffer_drain_accumulator;

    logic       clock = 1'b0;
    logic       reset;
    logic       empty;
    logic [2:0] din;
    logic       rd;
    logic [6:0] sum;
    logic       sum_valid;
    logic       sum_ready;
    logic       sat;

    logic       big_empty;
    logic [2:0] big_din;
    logic       big_rd;
    logic [6:0] big_sum;
    logic       big_sum_valid;
    logic       big_sum_ready;
    logic       big_sat;

    int checks = 0;
    int fails  = 0;

    logic [2:0] words [0:7];
    int nreads;
    int first_rd;
    int valid_cyc;
    int rd_while_empty;
    bit got_valid;

    always #5 clock = ~clock;

    buffer_drain_accumulator u_dut (
        .clock     (clock),
        .reset     (reset),
        .empty     (empty),
        .din       (din),
        .rd        (rd),
        .sum       (sum),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sat       (sat)
    );

    buffer_drain_accumulator #(.DATA_W(3), .COUNT(32), .SUM_W(7)) u_big (
        .clock     (clock),
        .reset     (reset),
        .empty     (big_empty),
        .din       (big_din),
        .rd        (big_rd),
        .sum       (big_sum),
        .sum_valid (big_sum_valid),
        .sum_ready (big_sum_ready),
        .sat       (big_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Emulates the upstream buffer: dout shows the word for the read issued in the previous cycle.
    task automatic collect(input bit toggle, input int read_limit, input int max_cycles);
        bit prev_rd = 1'b0;
        int cyc = 0;
        nreads = 0;
        first_rd = -1;
        valid_cyc = -1;
        rd_while_empty = 0;
        got_valid = 1'b0;
        while (cyc < max_cycles) begin
            @(negedge clock);
            if (sum_valid === 1'b1) begin
                got_valid = 1'b1;
                valid_cyc = cyc;
                break;
            end
            empty = (nreads >= read_limit) || (toggle && (cyc % 2 == 0));
            din = prev_rd ? words[nreads - 1] : 3'd5;
            #1;
            if (rd === 1'b1) begin
                if (empty) rd_while_empty++;
                if (first_rd < 0) first_rd = cyc;
                nreads++;
            end
            prev_rd = (rd === 1'b1);
            cyc++;
        end
    endtask

    task automatic hold_check(input int cycles, input logic [6:0] exp_sum);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            sum_ready = 1'b0;
            empty = 1'b0;
            din = 3'd7;
            #1;
            check("hold_valid", 32'(sum_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(exp_sum));
            check("hold_rd", 32'(rd), 32'd0);
        end
    endtask

    task automatic consume();
        @(negedge clock);
        sum_ready = 1'b1;
        empty = 1'b1;
        @(negedge clock);
        sum_ready = 1'b0;
        check("consume_valid_drop", 32'(sum_valid), 32'd0);
    endtask

    initial begin
        int bc;
        int bfirst;
        int bvalid;
        reset = 1'b1;
        empty = 1'b0;
        din = 3'd0;
        sum_ready = 1'b0;
        big_empty = 1'b1;
        big_din = 3'd7;
        big_sum_ready = 1'b0;

        repeat (2) @(negedge clock);
        #1;
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_valid", 32'(sum_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_sat", 32'(sat), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        empty = 1'b1;

        // Eight words of 7.
        for (int i = 0; i < 8; i++) words[i] = 3'd7;
        collect(1'b0, 8, 40);
        check("t1_got_valid", 32'(got_valid), 32'd1);
        check("t1_reads", 32'(nreads), 32'd8);
        check("t1_latency", 32'(valid_cyc - first_rd), 32'd9);
        check("t1_sum", 32'(sum), 32'd56);
        check("t1_sat", 32'(sat), 32'd0);
        hold_check(5, 7'd56);
        consume();

        // Seven 7s then a 6.
        for (int i = 0; i < 7; i++) words[i] = 3'd7;
        words[7] = 3'd6;
        collect(1'b0, 8, 40);
        check("t2_got_valid", 32'(got_valid), 32'd1);
        check("t2_reads", 32'(nreads), 32'd8);
        check("t2_sum", 32'(sum), 32'd55);
        check("t2_sat", 32'(sat), 32'd0);
        consume();

        // Empty toggling every cycle, words of 1.
        for (int i = 0; i < 8; i++) words[i] = 3'd1;
        collect(1'b1, 8, 40);
        check("t3_got_valid", 32'(got_valid), 32'd1);
        check("t3_reads", 32'(nreads), 32'd8);
        check("t3_rd_while_empty", 32'(rd_while_empty), 32'd0);
        check("t3_sum", 32'(sum), 32'd8);
        consume();

        // Reset after four words of 7, then eight words of 2.
        for (int i = 0; i < 8; i++) words[i] = 3'd7;
        collect(1'b0, 4, 6);
        check("t4_partial_reads", 32'(nreads), 32'd4);
        check("t4_partial_valid", 32'(got_valid), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        empty = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t4_reset_valid", 32'(sum_valid), 32'd0);
        check("t4_reset_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 8; i++) words[i] = 3'd2;
        collect(1'b0, 8, 40);
        check("t4_got_valid", 32'(got_valid), 32'd1);
        check("t4_sum", 32'(sum), 32'd16);
        consume();

        // COUNT=32 instance, all words 7.
        bc = 0;
        bfirst = -1;
        bvalid = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (big_sum_valid === 1'b1) begin
                bvalid = c;
                break;
            end
            big_empty = 1'b0;
            #1;
            if (big_rd === 1'b1) begin
                if (bfirst < 0) bfirst = c;
                bc++;
            end
        end
        check("t5_got_valid", 32'(bvalid >= 0), 32'd1);
        check("t5_reads", 32'(bc), 32'd32);
        check("t5_latency", 32'(bvalid - bfirst), 32'd33);
`ifdef ACC_SATURATE_EN
        check("t5_sum", 32'(big_sum), 32'd127);
        check("t5_sat", 32'(big_sat), 32'd1);
`else
        check("t5_sum", 32'(big_sum), 32'd96);
        check("t5_sat", 32'(big_sat), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/buffer_drain_accumulator.md
BUFFER_DRAIN_ACCUMULATOR -- requirements
Module: buffer_drain_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 3, width of one buffer word.
REQ-002 SHALL have parameter COUNT, default 8, words summed per result (range 2..255).
REQ-003 SHALL have parameter SUM_W, default 7, accumulator and result width.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port empty  input  1  upstream circular buffer empty flag.
REQ-007 SHALL have port din  input  DATA_W  upstream buffer read data (dout of the buffer).
REQ-008 SHALL have port rd  output  1  read request to the upstream buffer.
REQ-009 SHALL have port sum  output  SUM_W  completed sum of COUNT words.
REQ-010 SHALL have port sum_valid  output  1  sum holds a completed result.
REQ-011 SHALL have port sum_ready  input  1  downstream accepts sum.
REQ-012 SHALL have port sat  output  1  result clamped (see Configuration).

Function
REQ-013 SHALL implement two states, COLLECT and HOLD; reset enters COLLECT.
REQ-014 SHALL drive rd combinationally = (state==COLLECT) && !empty && (issued < COUNT).
REQ-015 SHALL treat din as valid one cycle after a cycle with rd=1: a registered rd_q flags the capture cycle.
REQ-016 SHALL, on each rd_q=1 cycle, add zero-extended din to the accumulator and increment the accepted count.
REQ-017 SHALL sustain one read per cycle while empty=0; empty=1 gaps insert idle cycles and lose no data.
REQ-018 SHALL never issue more than COUNT reads per result; issued and accepted counters are ceil(log2(COUNT+1)) bits.
REQ-019 SHALL, in the cycle after the COUNT-th word is accumulated, enter HOLD, with sum_valid=1 and sum/sat the final values.
REQ-020 SHALL hold sum, sat and sum_valid stable in HOLD while sum_ready=0; rd=0 throughout HOLD.
REQ-021 SHALL, on a clock edge with sum_valid && sum_ready, clear the accumulator, counters and sat, return to COLLECT and deassert sum_valid; rd may assert in the next cycle.
REQ-022 SHALL ignore sum_ready while sum_valid=0.
REQ-023 SHALL ignore empty and din in HOLD; a rd_q capture cannot be pending on HOLD entry.
REQ-024 SHALL yield result latency of COUNT+1 cycles from the first rd to sum_valid with empty held 0.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, set state=COLLECT, accumulator=0, counters=0, rd_q=0, sum=0, sum_valid=0, sat=0.
REQ-026 SHALL drive rd=0 in any cycle where reset=1.
REQ-027 SHALL discard a partial sum on reset mid-COLLECT and any unconsumed result on reset in HOLD; reset does not restore words already read from the buffer.

Configuration
REQ-028 SHALL use macro ACC_SATURATE_EN to select overflow handling.
REQ-029 SHALL, with ACC_SATURATE_EN defined, clamp the accumulator at 2^SUM_W-1 when an addition would exceed it, and set sat=1 until the result is consumed.
REQ-030 SHALL, without ACC_SATURATE_EN, wrap the accumulator modulo 2^SUM_W and tie sat to 0.

Verification
REQ-031 SHALL cover: defaults, empty=0, eight words of 7 -> eight rd pulses, sum=56, sum_valid 9 cycles after first rd, sat=0.
REQ-032 SHALL cover: seven words of 7 then one 6 -> sum=55, not 56; rd deasserts after the 8th read.
REQ-033 SHALL cover: empty toggling 1/0 each cycle, eight words of 1 -> sum=8, rd never asserted while empty=1.
REQ-034 SHALL cover: sum_ready=0 for 5 cycles after sum_valid -> sum stable, rd=0; sum_ready=1 -> sum_valid drops next edge, next result starts from 0.
REQ-035 SHALL cover: reset after 4 words of 7 accumulated, then eight words of 2 -> sum=16.
REQ-036 SHALL cover: COUNT=32, SUM_W=7, all words 7 -> sum=127, sat=1 with ACC_SATURATE_EN; sum=96, sat=0 without.
